jelly_bit_deserializer: RTL and testbench



---
 rtl/jelly_bit_deserializer.sv | 113 +++++++++++
 tb/tb_jelly_bit_deserializer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jelly_bit_deserializer.sv
// Purpose: collects a serial bit stream MSB-first into WIDTH-bit words on a valid/ready port.
// Latency: the word is valid after the edge that accepts its last bit or flush, if the slot is free.
// Backpressure: s_ready is registered-only; it falls once a complete word waits behind a stalled slot.
//
// Ports:
//   reset, clk      asynchronous active-high reset, rising-edge clock
//   cke             clock enable; all state and handshakes freeze while low
//   flush           close the current partial word (only with JELLY_BIT_DESERIALIZER_FLUSH_EN)
//   s_data/s_valid/s_ready           serial input bit
//   m_data/m_count/m_valid/m_ready   assembled word, right-aligned, with its bit count
//
// Build option: define JELLY_BIT_DESERIALIZER_FLUSH_EN to enable flush and partial counts.
// Without it, flush is ignored and m_count reads WIDTH for every word.

module jelly_bit_deserializer #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic                   cke,
  input  logic                   flush,
  input  logic                   s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic [COUNT_WIDTH-1:0] m_count,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(WIDTH);

  logic [WIDTH-1:0]       asm_data;
  logic [WIDTH-1:0]       next_data;
  logic [COUNT_WIDTH-1:0] asm_count;
  logic [COUNT_WIDTH-1:0] next_count;
  logic                   accept;
  logic                   held;
  logic                   complete;
  logic                   slot_free;
  logic                   transfer;

`ifdef JELLY_BIT_DESERIALIZER_FLUSH_EN
  // Set when a finished word (full or flushed) is waiting for the slot.
  logic closed;

  assign held     = closed | (asm_count == FULL_COUNT);
  // A flush only closes a word that has at least one bit, counting a bit
  // accepted on the same edge; an empty flush never makes a zero-length word.
  assign complete = held | (next_count == FULL_COUNT) |
                    (flush & (next_count != '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      closed <= 1'b0;
    end else if (cke) begin
      closed <= complete & !slot_free;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush;

  assign held     = (asm_count == FULL_COUNT);
  assign complete = held | (next_count == FULL_COUNT);
`endif

  assign s_ready   = !held;
  assign slot_free = !m_valid | m_ready;
  assign transfer  = complete & slot_free;

  // Shifting in at the LSB keeps a partial word right-aligned, and since the
  // register is cleared on every transfer the unused upper bits stay zero.
  always_comb begin
    accept     = s_valid & s_ready;
    next_data  = asm_data;
    next_count = asm_count;
    if (accept) begin
      next_data  = {asm_data[WIDTH-2:0], s_data};
      next_count = asm_count + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_data  <= '0;
      asm_count <= '0;
      m_data    <= '0;
      m_count   <= '0;
      m_valid   <= 1'b0;
    end else if (cke) begin
      if (transfer) begin
        m_data    <= next_data;
`ifdef JELLY_BIT_DESERIALIZER_FLUSH_EN
        m_count   <= next_count;
`else
        m_count   <= FULL_COUNT;
`endif
        m_valid   <= 1'b1;
        asm_data  <= '0;
        asm_count <= '0;
      end else begin
        if (m_ready) begin
          m_valid <= 1'b0;
        end
        asm_data  <= next_data;
        asm_count <= next_count;
      end
    end
  end

endmodule

// File: tb/tb_jelly_bit_deserializer.sv
// Directed bench for jelly_bit_deserializer with a word scoreboard.
// Expected words are queued as stimulus is driven and compared when the DUT hands them off.
// Flush scenarios are built only when JELLY_BIT_DESERIALIZER_FLUSH_EN is defined.

module tb_jelly_bit_deserializer;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          cke     = 1'b1;
  logic          flush   = 1'b0;
  logic          s_data  = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  m_data;
  logic [CW-1:0] m_count;
  logic          m_valid;
  logic          m_ready = 1'b1;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [CW-1:0] count;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  jelly_bit_deserializer #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .reset   (reset),
    .clk     (clk),
    .cke     (cke),
    .flush   (flush),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_count (m_count),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, input int n);
    exp_t e;
    e.data  = d;
    e.count = CW'(n);
    sb.push_back(e);
  endtask

  // Holds one bit on the input until it is accepted, optionally with flush.
  task automatic send_bit(input logic b, input logic fl);
    int guard;
    guard   = 0;
    s_valid = 1'b1;
    s_data  = b;
    flush   = fl;
    @(negedge clk);
    while (!(s_ready && cke) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("s_ready_wait", 32'(guard < 50), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    flush   = 1'b0;
  endtask

  // Sends the low n bits of d, most significant first.
  task automatic send_word(input logic [W-1:0] d, input int n);
    logic [W-1:0] v;
    v = d;
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], 1'b0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // Output monitor: handshakes and hold-while-stalled, sampled on the falling edge.
  exp_t          got;
  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_data;
  logic [CW-1:0] prev_count;

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
        chk("hold_count", 32'(m_count), 32'(prev_count));
      end
      if (cke && m_valid && m_ready) begin
        chk("word_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          got = sb.pop_front();
          chk("m_data", 32'(m_data), 32'(got.data));
`ifdef JELLY_BIT_DESERIALIZER_FLUSH_EN
          chk("m_count", 32'(m_count), 32'(got.count));
`else
          chk("m_count", 32'(m_count), 32'(W));
`endif
        end
      end
    end
    prev_stall = !reset && m_valid && !m_ready;
    prev_data  = m_data;
    prev_count = m_count;
  end

  initial begin
    if (W >= (1 << CW)) begin
      $display("FAIL param WIDTH=%0d does not fit COUNT_WIDTH=%0d", W, CW);
      $fatal(1);
    end

    // Reset state.
    step();
    step();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_count", 32'(m_count), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    reset = 1'b0;
    step();

    // Single word, free slot: valid right after the last bit, for one cycle.
    push(8'hB2, 8);
    send_word(8'hB2, 8);
    chk("lat_valid", 32'(m_valid), 32'd1);
    chk("lat_data", 32'(m_data), 32'hB2);
    step();
    chk("one_cycle_valid", 32'(m_valid), 32'd0);

    // Full backpressure: two words fill slot and assembly, then drain.
    m_ready = 1'b0;
    push(8'hB2, 8);
    push(8'h5A, 8);
    send_word(8'hB2, 8);
    chk("bp_ready_after8", 32'(s_ready), 32'd1);
    send_word(8'h5A, 8);
    chk("bp_ready_after16", 32'(s_ready), 32'd0);
    chk("bp_slot_data", 32'(m_data), 32'hB2);
    m_ready = 1'b1;
    step();
    chk("bp_second_valid", 32'(m_valid), 32'd1);
    chk("bp_second_data", 32'(m_data), 32'h5A);
    chk("bp_ready_back", 32'(s_ready), 32'd1);
    step();
    chk("bp_drained", 32'(m_valid), 32'd0);

    // Clock enable low mid-word while a word sits in the slot.
    m_ready = 1'b0;
    push(8'hA5, 8);
    send_word(8'hA5, 8);
    push(8'hC3, 8);
    send_word(8'h0C, 4);
    cke     = 1'b0;
    s_valid = 1'b1;
    s_data  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("cke_valid_hold", 32'(m_valid), 32'd1);
      chk("cke_data_hold", 32'(m_data), 32'hA5);
      chk("cke_s_ready", 32'(s_ready), 32'd1);
    end
    s_valid = 1'b0;
    cke     = 1'b1;
    step();
    chk("cke_consumed", 32'(m_valid), 32'd0);
    send_word(8'h03, 4);
    step();

    // Reset mid-word with a word held in the slot: both are discarded.
    m_ready = 1'b0;
    send_word(8'hAA, 8);
    send_word(8'h1F, 5);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_count", 32'(m_count), 32'd0);
    chk("mid_rst_s_ready", 32'(s_ready), 32'd1);
    reset   = 1'b0;
    m_ready = 1'b1;
    step();
    push(8'hFF, 8);
    send_word(8'hFF, 8);
    step();

`ifdef JELLY_BIT_DESERIALIZER_FLUSH_EN
    // Partial word closed by a separate flush.
    push(8'h05, 3);
    send_word(8'h05, 3);
    do_flush();
    chk("fl_partial_valid", 32'(m_valid), 32'd1);
    step();

    // Flush together with the last bit.
    push(8'h06, 3);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    chk("fl_same_cycle_valid", 32'(m_valid), 32'd1);
    step();

    // Flush on an empty assembly register.
    do_flush();
    chk("fl_empty_valid", 32'(m_valid), 32'd0);
    step();
    chk("fl_empty_valid2", 32'(m_valid), 32'd0);

    // Flush on the final bit of a full word gives exactly one word.
    push(8'hFF, 8);
    send_word(8'h7F, 7);
    send_bit(1'b1, 1'b1);
    step();
    step();

    // Flush while a closed word waits behind a stalled slot.
    m_ready = 1'b0;
    push(8'h05, 3);
    send_word(8'h05, 3);
    do_flush();
    push(8'h03, 2);
    send_word(8'h03, 2);
    do_flush();
    chk("fl_closed_ready", 32'(s_ready), 32'd0);
    do_flush();
    chk("fl_closed_ready2", 32'(s_ready), 32'd0);
    m_ready = 1'b1;
    step();
    chk("fl_closed_release", 32'(s_ready), 32'd1);
    step();
    step();
`endif

    repeat (5) step();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
